conv_row_feeder: RTL



---
 rtl/conv_pkg.sv | 23 ++
 rtl/fmap_buffer.sv | 67 ++++++
 rtl/conv_row_feeder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the conv row feeder.
//   state_t  - feeder FSM state encoding
//   row_bits - width in bits of one zero-padded row (W pixels plus two pad slots)
//   cnt_bits - counter width for a range of n values, never less than 1 bit
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_CONV,
    ST_WAIT_ADD
  } state_t;

  function automatic int row_bits(input int data_w, input int w);
    return data_w * (w + 2);
  endfunction

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_buffer.sv
// fmap_buffer: D x H x W pixel store with one write port and three
// combinational padded-row read ports sharing a single channel select.
//   clk        - clock (write port only; contents are never cleared)
//   we_i       - write enable
//   waddr_i    - linear address d*H*W + row*W + col
//   wdata_i    - pixel to store
//   rd_d_i     - channel for all three reads
//   rd_rowN_i  - signed row index per read port; out-of-range rows read as 0
//   rowN_o     - padded row, slot 0 in the LSBs, column j in slot j+1
module fmap_buffer
  import conv_pkg::*;
#(
  parameter int D  = 4,
  parameter int H  = 12,
  parameter int W  = 12,
  parameter int DW = 8
) (
  input  logic                              clk,
  input  logic                              we_i,
  input  logic [cnt_bits(D*H*W)-1:0]        waddr_i,
  input  logic [DW-1:0]                     wdata_i,
  input  logic [cnt_bits(D)-1:0]            rd_d_i,
  input  logic signed [cnt_bits(H)+1:0]     rd_row0_i,
  input  logic signed [cnt_bits(H)+1:0]     rd_row1_i,
  input  logic signed [cnt_bits(H)+1:0]     rd_row2_i,
  output logic [row_bits(DW, W)-1:0]        row0_o,
  output logic [row_bits(DW, W)-1:0]        row1_o,
  output logic [row_bits(DW, W)-1:0]        row2_o
);

  localparam int DEPTH = D * H * W;
  localparam int AW    = cnt_bits(DEPTH);
  localparam int DIW   = cnt_bits(D);
  localparam int RSW   = cnt_bits(H) + 2;
  localparam int RB    = row_bits(DW, W);
  localparam logic signed [RSW-1:0] H_S = RSW'(H);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The sign bit catches row -1 (above the top edge); H_S catches row H.
  function automatic logic [RB-1:0] read_row(input logic [DIW-1:0] d,
                                             input logic signed [RSW-1:0] row);
    logic [RB-1:0] v;
    logic [AW-1:0] a;
    int            base;
    v = '0;
    if (!row[RSW-1] && (row < H_S)) begin
      base = int'(d) * H * W + int'(row) * W;
      for (int j = 0; j < W; j++) begin
        a = AW'(base + j);
        v[(j+1)*DW +: DW] = mem_q[a];
      end
    end
    return v;
  endfunction

  assign row0_o = read_row(rd_d_i, rd_row0_i);
  assign row1_o = read_row(rd_d_i, rd_row1_i);
  assign row2_o = read_row(rd_d_i, rd_row2_i);

endmodule

// File: rtl/conv_row_feeder.sv
// conv_row_feeder: buffers one D x H x W int8 feature map from a pixel stream,
// then for every output row r and channel d presents the padded rows r-1, r,
// r+1 to the depth-serial conv engine with a one-cycle image_start_o pulse.
//   clk            - clock
//   rstn_i         - synchronous reset, active high
//   start_i        - begin a frame load (IDLE only)
//   pix_i/valid/ready - pixel stream, channel-major (d, row, col)
//   image0/1/2_o   - rows r-1, r, r+1 of channel d, zero padded
//   image_start_o  - rows valid this cycle
//   conv_done_i    - engine finished the current depth pass
//   add_done_i     - add stage finished the current output row
//   busy_o         - not IDLE
//   frame_done_o   - pulse after the last row's add_done_i
//
// state      | meaning
// IDLE       | waiting for start_i
// LOAD       | accepting pixels into the buffer
// ISSUE      | latch rows for (r, d) and pulse image_start_o
// WAIT_CONV  | rows held until the engine reports conv_done_i
// WAIT_ADD   | all depths issued, waiting for add_done_i
module conv_row_feeder
  import conv_pkg::*;
#(
  parameter int D                = 4,
  parameter int H                = 12,
  parameter int W                = 12,
  parameter int input_DATA_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rstn_i,
  input  logic                                      start_i,
  input  logic [input_DATA_WIDTH-1:0]               pix_i,
  input  logic                                      pix_valid_i,
  output logic                                      pix_ready_o,
  output logic [row_bits(input_DATA_WIDTH, W)-1:0]  image0_o,
  output logic [row_bits(input_DATA_WIDTH, W)-1:0]  image1_o,
  output logic [row_bits(input_DATA_WIDTH, W)-1:0]  image2_o,
  output logic                                      image_start_o,
  input  logic                                      conv_done_i,
  input  logic                                      add_done_i,
  output logic                                      busy_o,
  output logic                                      frame_done_o
);

  localparam int TOTAL = D * H * W;
  localparam int CW    = cnt_bits(TOTAL);
  localparam int DIW   = cnt_bits(D);
  localparam int HW    = cnt_bits(H);
  localparam int RSW   = HW + 2;
  localparam int RB    = row_bits(input_DATA_WIDTH, W);

  localparam logic [CW-1:0]         CNT_LAST = CW'(TOTAL - 1);
  localparam logic [DIW-1:0]        D_LAST   = DIW'(D - 1);
  localparam logic [HW-1:0]         R_LAST   = HW'(H - 1);
  localparam logic signed [RSW-1:0] ONE_S    = RSW'(1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DIW-1:0]  d_q, d_d;
  logic [HW-1:0]   r_q, r_d;
  logic [RB-1:0]   img0_q, img0_d, img1_q, img1_d, img2_q, img2_d;
  logic            start_q, start_d;
  logic            frame_done_q, frame_done_d;

  logic            buf_we;
  logic [RB-1:0]   rd0, rd1, rd2;
  logic signed [RSW-1:0] row_c, row_t, row_b;

  // Two extra bits so r-1 can go negative and r+1 can reach H without wrapping.
  assign row_c = signed'({2'b00, r_q});
  assign row_t = row_c - ONE_S;
  assign row_b = row_c + ONE_S;

  fmap_buffer #(
    .D  (D),
    .H  (H),
    .W  (W),
    .DW (input_DATA_WIDTH)
  ) u_fmap_buffer (
    .clk       (clk),
    .we_i      (buf_we),
    .waddr_i   (cnt_q),
    .wdata_i   (pix_i),
    .rd_d_i    (d_q),
    .rd_row0_i (row_t),
    .rd_row1_i (row_c),
    .rd_row2_i (row_b),
    .row0_o    (rd0),
    .row1_o    (rd1),
    .row2_o    (rd2)
  );

  always_ff @(posedge clk) begin
    if (rstn_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      d_q          <= '0;
      r_q          <= '0;
      img0_q       <= '0;
      img1_q       <= '0;
      img2_q       <= '0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      r_q          <= r_d;
      img0_q       <= img0_d;
      img1_q       <= img1_d;
      img2_q       <= img2_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          d_d     = '0;
          r_d     = '0;
        end
      end
      ST_LOAD: begin
        if (pix_valid_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ISSUE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT_CONV;
      ST_WAIT_CONV: begin
        if (conv_done_i) begin
          if (d_q != D_LAST) begin
            d_d     = d_q + 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_WAIT_ADD;
          end
        end
      end
      ST_WAIT_ADD: begin
        if (add_done_i) begin
          if (r_q != R_LAST) begin
            r_d     = r_q + 1'b1;
            d_d     = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    img0_d       = img0_q;
    img1_d       = img1_q;
    img2_d       = img2_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    buf_we       = (state_q == ST_LOAD) && pix_valid_i;
    if (state_q == ST_ISSUE) begin
      img0_d  = rd0;
      img1_d  = rd1;
      img2_d  = rd2;
      start_d = 1'b1;
    end
    if ((state_q == ST_WAIT_ADD) && add_done_i && (r_q == R_LAST)) begin
      frame_done_d = 1'b1;
    end
  end

  assign pix_ready_o   = (state_q == ST_LOAD);
  assign busy_o        = (state_q != ST_IDLE);
  assign image0_o      = img0_q;
  assign image1_o      = img1_q;
  assign image2_o      = img2_q;
  assign image_start_o = start_q;
  assign frame_done_o  = frame_done_q;

endmodule
